// File: rtl/ibex_rvfi_trace_buf.sv
// rtl/ibex_rvfi_trace_buf.sv - RVFI retirement trace buffer with stream, circular and PC-triggered capture
module ibex_rvfi_trace_buf #(
  parameter int unsigned Depth   = 16,
  parameter int unsigned TsWidth = 16,
  localparam int unsigned AW     = $clog2(Depth),
  localparam int unsigned RecW   = 103 + TsWidth
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              rvfi_valid_i,
  input  logic [31:0]       rvfi_pc_rdata_i,
  input  logic [31:0]       rvfi_insn_i,
  input  logic              rvfi_trap_i,
  input  logic              rvfi_intr_i,
  input  logic [4:0]        rvfi_rd_addr_i,
  input  logic [31:0]       rvfi_rd_wdata_i,
  input  logic [1:0]        mode_i,
  input  logic [31:0]       trig_pc_i,
  input  logic [AW:0]       post_cnt_i,
  input  logic              clear_i,
  output logic              rd_valid_o,
  input  logic              rd_ready_i,
  output logic [RecW-1:0]   rd_data_o,
  output logic [AW:0]       level_o,
  output logic              triggered_o,
  output logic              frozen_o,
  output logic [15:0]       drop_cnt_o
);

  typedef enum logic [1:0] {ST_OFF, ST_RUN, ST_POST, ST_FROZEN} state_e;

  localparam logic [1:0]  MODE_OFF    = 2'd0;
  localparam logic [1:0]  MODE_STREAM = 2'd1;
  localparam logic [1:0]  MODE_TRIG   = 2'd3;
  localparam logic [AW:0] DEPTH_L     = (AW+1)'(Depth);
  localparam logic [AW:0] ONE_L       = (AW+1)'(1);

  state_e              state_q, state_d;
  logic [1:0]          mode_q;
  logic [TsWidth-1:0]  ts_q;
  logic [RecW-1:0]     mem [Depth];
  logic [AW-1:0]       wptr_q, rptr_q;
  logic [AW:0]         level_q;
  logic [AW:0]         post_q, post_d;
  logic [15:0]         drop_q;
  logic                trig_q;

  logic                flush, full, pop, push, drop, overwrite, trig_set, pc_match;
  logic [RecW-1:0]     rec;

  assign rec      = {rvfi_trap_i, rvfi_intr_i, rvfi_rd_addr_i, rvfi_pc_rdata_i,
                     rvfi_insn_i, rvfi_rd_wdata_i, ts_q};
  assign flush    = clear_i || (mode_i != mode_q);
  assign full     = (level_q == DEPTH_L);
  assign pc_match = (rvfi_pc_rdata_i == trig_pc_i);

  assign rd_valid_o  = (level_q != '0);
  assign pop         = rd_valid_o && rd_ready_i;
  assign rd_data_o   = rd_valid_o ? mem[rptr_q] : '0;
  assign level_o     = level_q;
  assign triggered_o = trig_q;
  assign frozen_o    = (state_q == ST_FROZEN);
  assign drop_cnt_o  = drop_q;

  // A full buffer with no pop in CIRC/TRIG/POST drops the oldest entry.
  assign overwrite = push && full && !pop;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= ST_OFF;
      post_q  <= '0;
    end else begin
      state_q <= state_d;
      post_q  <= post_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    post_d   = post_q;
    push     = 1'b0;
    drop     = 1'b0;
    trig_set = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        if (rvfi_valid_i) begin
          if (mode_q == MODE_STREAM) begin
            if (!full || pop) push = 1'b1;
            else              drop = 1'b1;
          end else begin
            push = 1'b1;
            if (mode_q == MODE_TRIG && pc_match) begin
              trig_set = 1'b1;
              if (post_cnt_i == '0) begin
                state_d = ST_FROZEN;
              end else begin
                post_d  = post_cnt_i;
                state_d = ST_POST;
              end
            end
          end
        end
      end
      ST_POST: begin
        if (rvfi_valid_i) begin
          push   = 1'b1;
          post_d = post_q - ONE_L;
          if (post_q == ONE_L) state_d = ST_FROZEN;
        end
      end
      default: ;
    endcase
    // Flush overrides everything decided above in the same cycle.
    if (flush) begin
      state_d  = (mode_i == MODE_OFF) ? ST_OFF : ST_RUN;
      post_d   = '0;
      push     = 1'b0;
      drop     = 1'b0;
      trig_set = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ts_q    <= '0;
      mode_q  <= MODE_OFF;
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      drop_q  <= '0;
      trig_q  <= 1'b0;
    end else begin
      ts_q   <= ts_q + TsWidth'(1);
      mode_q <= mode_i;
      if (flush) begin
        wptr_q  <= '0;
        rptr_q  <= '0;
        level_q <= '0;
        drop_q  <= '0;
        trig_q  <= 1'b0;
      end else begin
        if (push) wptr_q <= wptr_q + AW'(1);
        if (pop || overwrite) rptr_q <= rptr_q + AW'(1);
        if (push && !pop && !full) level_q <= level_q + ONE_L;
        else if (pop && !push)     level_q <= level_q - ONE_L;
        if (drop && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
        if (trig_set) trig_q <= 1'b1;
      end
    end
  end

  // Storage is not reset; rd_data_o is gated by level so stale entries never show.
  always_ff @(posedge clk_i) begin
    if (push) mem[wptr_q] <= rec;
  end

endmodule

// File: tb/tb_ibex_rvfi_trace_buf.sv
// tb/tb_ibex_rvfi_trace_buf.sv - directed self-checking bench for ibex_rvfi_trace_buf
module tb_ibex_rvfi_trace_buf;

  localparam int TSW  = 16;
  localparam int RECW = 103 + TSW;

  logic            clk = 1'b0;
  logic            rst_ni;
  logic            rvfi_valid_i;
  logic [31:0]     rvfi_pc_rdata_i;
  logic [31:0]     rvfi_insn_i;
  logic            rvfi_trap_i;
  logic            rvfi_intr_i;
  logic [4:0]      rvfi_rd_addr_i;
  logic [31:0]     rvfi_rd_wdata_i;
  logic [1:0]      mode_i;
  logic [31:0]     trig_pc_i;
  logic [4:0]      post_cnt_i;
  logic            clear_i;
  logic            rd_valid_o;
  logic            rd_ready_i;
  logic [RECW-1:0] rd_data_o;
  logic [4:0]      level_o;
  logic            triggered_o;
  logic            frozen_o;
  logic [15:0]     drop_cnt_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ibex_rvfi_trace_buf #(.Depth(16), .TsWidth(TSW)) dut (
    .clk_i           (clk),
    .rst_ni          (rst_ni),
    .rvfi_valid_i    (rvfi_valid_i),
    .rvfi_pc_rdata_i (rvfi_pc_rdata_i),
    .rvfi_insn_i     (rvfi_insn_i),
    .rvfi_trap_i     (rvfi_trap_i),
    .rvfi_intr_i     (rvfi_intr_i),
    .rvfi_rd_addr_i  (rvfi_rd_addr_i),
    .rvfi_rd_wdata_i (rvfi_rd_wdata_i),
    .mode_i          (mode_i),
    .trig_pc_i       (trig_pc_i),
    .post_cnt_i      (post_cnt_i),
    .clear_i         (clear_i),
    .rd_valid_o      (rd_valid_o),
    .rd_ready_i      (rd_ready_i),
    .rd_data_o       (rd_data_o),
    .level_o         (level_o),
    .triggered_o     (triggered_o),
    .frozen_o        (frozen_o),
    .drop_cnt_o      (drop_cnt_o)
  );

  typedef struct {
    logic [1:0]  mode;
    logic        clr;
    logic        vld;
    logic [31:0] pc;
    logic        rdy;
    logic [4:0]  lvl;
    logic        ev;
    logic [31:0] epc;
    logic [15:0] drop;
    logic        trig;
    logic        frz;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Non-PC record fields are derived from the PC so any retirement is checkable.
  task automatic drive(input logic [1:0] m, input logic c, input logic v,
                       input logic [31:0] p, input logic r);
    mode_i          = m;
    clear_i         = c;
    rvfi_valid_i    = v;
    rvfi_pc_rdata_i = p;
    rvfi_insn_i     = ~p;
    rvfi_rd_wdata_i = p + 32'd1;
    rvfi_rd_addr_i  = p[6:2];
    rvfi_trap_i     = p[2];
    rvfi_intr_i     = p[3];
    rd_ready_i      = r;
  endtask

  function automatic logic [102:0] exp_hi(input logic [31:0] p);
    return {p[2], p[3], p[6:2], p, ~p, p + 32'd1};
  endfunction

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_valid"}, rd_valid_o, 0);
    chk({tag, "_data"}, rd_data_o, 0);
    chk({tag, "_level"}, level_o, 0);
    chk({tag, "_trig"}, triggered_o, 0);
    chk({tag, "_frozen"}, frozen_o, 0);
    chk({tag, "_drop"}, drop_cnt_o, 0);
  endtask

  initial begin
    logic [31:0] p;
    logic [TSW-1:0] prev_ts;

    rst_ni     = 1'b0;
    trig_pc_i  = 32'h200;
    post_cnt_i = 5'd0;
    drive(2'd0, 1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    tick();
    chk_zero_outputs("reset");
    rst_ni = 1'b1;

    //         mode clr vld pc        rdy  lvl ev epc        drop trig frz
    vecs[0]  = '{2'd0, 0, 0, 32'h0,   0,   0, 0, 32'h0,   0,   0, 0};
    vecs[1]  = '{2'd1, 0, 1, 32'h10,  0,   0, 0, 32'h0,   0,   0, 0};
    vecs[2]  = '{2'd1, 0, 1, 32'h14,  0,   1, 1, 32'h14,  0,   0, 0};
    vecs[3]  = '{2'd1, 0, 1, 32'h18,  1,   1, 1, 32'h18,  0,   0, 0};
    vecs[4]  = '{2'd1, 0, 0, 32'h0,   0,   1, 1, 32'h18,  0,   0, 0};
    vecs[5]  = '{2'd1, 1, 1, 32'h1C,  1,   0, 0, 32'h0,   0,   0, 0};
    vecs[6]  = '{2'd3, 0, 1, 32'h200, 0,   0, 0, 32'h0,   0,   0, 0};
    vecs[7]  = '{2'd3, 0, 1, 32'h200, 0,   1, 1, 32'h200, 0,   1, 1};
    vecs[8]  = '{2'd3, 0, 1, 32'h204, 0,   1, 1, 32'h200, 0,   1, 1};
    vecs[9]  = '{2'd3, 0, 0, 32'h0,   1,   0, 0, 32'h0,   0,   1, 1};
    vecs[10] = '{2'd2, 0, 1, 32'h300, 0,   0, 0, 32'h0,   0,   0, 0};
    vecs[11] = '{2'd2, 0, 1, 32'h304, 0,   1, 1, 32'h304, 0,   0, 0};

    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].mode, vecs[i].clr, vecs[i].vld, vecs[i].pc, vecs[i].rdy);
      tick();
      chk($sformatf("vec%0d_level", i), level_o, vecs[i].lvl);
      chk($sformatf("vec%0d_valid", i), rd_valid_o, vecs[i].ev);
      if (vecs[i].ev) chk($sformatf("vec%0d_rec", i), rd_data_o[RECW-1:TSW], exp_hi(vecs[i].epc));
      else            chk($sformatf("vec%0d_data0", i), rd_data_o, 0);
      chk($sformatf("vec%0d_drop", i), drop_cnt_o, vecs[i].drop);
      chk($sformatf("vec%0d_trig", i), triggered_o, vecs[i].trig);
      chk($sformatf("vec%0d_frozen", i), frozen_o, vecs[i].frz);
    end

    // STREAM overflow, then a push+pop on a full buffer
    drive(2'd1, 1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    for (int i = 0; i < 20; i++) begin
      drive(2'd1, 1'b0, 1'b1, 32'h1000 + 32'(4 * i), 1'b0);
      tick();
    end
    chk("stream_level", level_o, 16);
    chk("stream_drop", drop_cnt_o, 4);
    drive(2'd1, 1'b0, 1'b1, 32'h2000, 1'b1);
    tick();
    chk("stream_pushpop_level", level_o, 16);
    chk("stream_pushpop_drop", drop_cnt_o, 4);
    prev_ts = '0;
    for (int k = 0; k < 16; k++) begin
      p = (k < 15) ? 32'h1004 + 32'(4 * k) : 32'h2000;
      chk($sformatf("stream_drain%0d_valid", k), rd_valid_o, 1);
      chk($sformatf("stream_drain%0d_rec", k), rd_data_o[RECW-1:TSW], exp_hi(p));
      if (k > 0) chk($sformatf("stream_drain%0d_ts_inc", k), rd_data_o[TSW-1:0] > prev_ts, 1);
      prev_ts = rd_data_o[TSW-1:0];
      drive(2'd1, 1'b0, 1'b0, 32'h0, 1'b1);
      tick();
    end
    chk("stream_empty_valid", rd_valid_o, 0);
    chk("stream_empty_level", level_o, 0);

    // CIRC overwrite, then a mode change with records held
    drive(2'd2, 1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    for (int i = 0; i < 20; i++) begin
      drive(2'd2, 1'b0, 1'b1, 32'h100 + 32'(4 * i), 1'b0);
      tick();
    end
    chk("circ_level", level_o, 16);
    chk("circ_drop", drop_cnt_o, 0);
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("circ_drain%0d_rec", k), rd_data_o[RECW-1:TSW], exp_hi(32'h110 + 32'(4 * k)));
      drive(2'd2, 1'b0, 1'b0, 32'h0, 1'b1);
      tick();
    end
    chk("circ_empty_valid", rd_valid_o, 0);
    for (int i = 0; i < 5; i++) begin
      drive(2'd2, 1'b0, 1'b1, 32'h400 + 32'(4 * i), 1'b0);
      tick();
    end
    chk("circ_five_level", level_o, 5);
    drive(2'd1, 1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    chk("modechg_level", level_o, 0);
    chk("modechg_valid", rd_valid_o, 0);

    // TRIG with three post-trigger records
    post_cnt_i = 5'd3;
    drive(2'd3, 1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    for (int i = 0; i < 13; i++) begin
      p = 32'h1F0 + 32'(4 * i);
      drive(2'd3, 1'b0, 1'b1, p, 1'b0);
      tick();
      chk($sformatf("trig_pc%0h_trig", p), triggered_o, p >= 32'h200);
      chk($sformatf("trig_pc%0h_frozen", p), frozen_o, p >= 32'h20C);
    end
    chk("trig_level", level_o, 8);
    chk("trig_drop", drop_cnt_o, 0);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("trig_drain%0d_rec", k), rd_data_o[RECW-1:TSW], exp_hi(32'h1F0 + 32'(4 * k)));
      drive(2'd3, 1'b0, 1'b0, 32'h0, 1'b1);
      tick();
    end
    chk("trig_empty_valid", rd_valid_o, 0);
    chk("trig_still_frozen", frozen_o, 1);

    // Reset during POST behaves like power-on reset
    drive(2'd2, 1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    drive(2'd3, 1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    drive(2'd3, 1'b0, 1'b1, 32'h200, 1'b0);
    tick();
    drive(2'd3, 1'b0, 1'b1, 32'h204, 1'b0);
    tick();
    chk("post_level", level_o, 2);
    chk("post_trig", triggered_o, 1);
    chk("post_frozen", frozen_o, 0);
    rst_ni = 1'b0;
    drive(2'd3, 1'b0, 1'b1, 32'h208, 1'b0);
    tick();
    chk_zero_outputs("midreset");
    rst_ni = 1'b1;
    drive(2'd3, 1'b0, 1'b1, 32'h200, 1'b0);
    tick();
    chk("after_reset_flush_level", level_o, 0);
    chk("after_reset_flush_trig", triggered_o, 0);
    drive(2'd3, 1'b0, 1'b1, 32'h200, 1'b0);
    tick();
    chk("after_reset_push_level", level_o, 1);
    chk("after_reset_push_trig", triggered_o, 1);
    chk("after_reset_push_frozen", frozen_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
